pq_push_alloc: RTL
==================

// Module: pq_push_alloc
// PURPOSE
//  Ingress stage directly upstream of the hardware priority queue.
//  - Accepts raw data from a requester and allocates a unique cell ID from an internal free list.
//  - Emits the assembled {data,id} cell (pq_pkg::cell_t layout) as a push to the queue.
//  - IDs return to the free list when the queue retires a cell, so no two live cells share an ID.
// PARAMETERS
//  QUEUE_DEPTH  16                        number of allocatable IDs (= queue capacity); IDs 0..QUEUE_DEPTH-1
//  DATA_WIDTH   8                         payload width
//  CNT_WIDTH    $clog2(QUEUE_DEPTH)       derived; free-list pointer width
//  ID_WIDTH     CNT_WIDTH+1               derived; ID and free-count width
// PORTS
//  clk_i          in   1                    clock
//  rst_ni         in   1                    reset, synchronous, active-low
//  req_valid_i    in   1                    requester has data
//  req_ready_o    out  1                    request accepted this cycle when valid&ready
//  req_data_i     in   DATA_WIDTH           request payload
//  push_valid_o   out  1                    cell push to queue valid
//  push_ready_i   in   1                    queue accepts push
//  push_cell_o    out  DATA_WIDTH+ID_WIDTH  {data, id}, data in MSBs
//  release_valid_i in  1                    queue retired a cell
//  release_id_i   in   ID_WIDTH             ID being retired
//  free_cnt_o     out  ID_WIDTH             IDs currently free
//  init_done_o    out  1                    free list populated
//  err_o          out  1                    one-cycle pulse on illegal release
// BEHAVIOUR
//  Reset values: req_ready_o=0, push_valid_o=0, push_cell_o=0, free_cnt_o=0, init_done_o=0, err_o=0.
//  Reset behaviour:
//   - rst_ni low at any edge clears all state and enters INIT.
//   - A pending push is dropped; push_valid_o is 0 the cycle after reset is sampled.
//  FSM:
//   - INIT: writes IDs 0,1,..,QUEUE_DEPTH-1 into the free-list FIFO, one per cycle; free_cnt_o increments each cycle.
//   - INIT -> RUN after QUEUE_DEPTH cycles; init_done_o=1 from the first RUN cycle and stays 1 until reset.
//   - In INIT: req_ready_o=0; release_valid_i is ignored and pulses err_o.
//  Ready rule (combinational from registered state):
//   - req_ready_o = RUN & (free_cnt_o!=0) & (!push_valid_o | push_ready_i).
//  Allocate:
//   - On req handshake, pop the free-list head.
//   - Next cycle push_valid_o=1 with push_cell_o={req_data_i, head ID}.
//   - Latency 1 cycle. Back-to-back requests sustain one push per cycle while push_ready_i=1.
//  Hold:
//   - While push_valid_o & !push_ready_i, push_cell_o is stable and req_ready_o=0.
//   - push_valid_o drops after handshake unless a new request was accepted that same cycle.
//  Release:
//   - release_valid_i writes release_id_i to the free-list tail; free_cnt_o += 1 next cycle.
//   - Release is never back-pressured.
//   - Release with free_cnt_o==QUEUE_DEPTH: dropped, err_o pulses.
//  Simultaneous allocate+release: both proceed; free_cnt_o unchanged.
//   - A request is not accepted when free_cnt_o==0, even with a same-cycle release.
//   - The released ID becomes allocatable one cycle later.
//  Pointers: head/tail wrap modulo QUEUE_DEPTH. free_cnt_o never exceeds QUEUE_DEPTH and never underflows.
//  Allocation order: FIFO over the free list, so IDs are reused in release order.
// CONFIGURATION
//  PQ_ALLOC_CHECK_EN defined:
//   - Maintains a QUEUE_DEPTH-bit in-use bitmap (set on allocate, cleared on release).
//   - A release with release_id_i>=QUEUE_DEPTH, or of an ID not in use, is ignored (no free-list write, count unchanged) and pulses err_o.
//  PQ_ALLOC_CHECK_EN undefined:
//   - No bitmap; releases are trusted. Only the full-list and INIT cases pulse err_o.
//   - An out-of-range ID is written as-is.
// TESTING (QUEUE_DEPTH=4, DATA_WIDTH=8)
//  1. Release reset -> init_done_o=1 after 4 cycles, free_cnt_o=4, req_ready_o=0 throughout INIT.
//  2. Four requests 0x11,0x22,0x33,0x44, push_ready_i=1 -> cells {0x11,0},{0x22,1},{0x33,2},{0x44,3} on consecutive cycles; free_cnt_o=0; fifth request sees req_ready_o=0.
//  3. push_ready_i=0 for 3 cycles with push_valid_o=1 -> push_cell_o stable, req_ready_o=0; push completes the cycle push_ready_i=1.
//  4. From empty list, release ID 2 -> free_cnt_o=1; next request gets ID 2. With free_cnt_o=1, release ID 0 together with a request -> request gets the prior head, free_cnt_o stays 1.
//  5. PQ_ALLOC_CHECK_EN: release ID 1 twice -> second release pulses err_o, free_cnt_o unchanged; release ID 5 -> err_o, ignored.
//  6. Assert rst_ni low while push_valid_o=1 and free_cnt_o=2 -> push_valid_o=0, free_cnt_o=0 next cycle; re-INIT yields free_cnt_o=4 after 4 cycles.

Source files
------------

// File: rtl/pq_push_alloc.sv
// Ingress allocator: pairs request data with a free cell ID from an internal free list and pushes {data,id} to the priority queue.
// Latency: one cycle from request handshake to push_valid_o. Releases are never stalled; requests stall when the list is empty or a push is held.
// Optional PQ_ALLOC_CHECK_EN adds an in-use bitmap that rejects out-of-range and double releases.

// Free-list storage: generic FIFO with a combinational head and an occupancy count.
// Latency: a write is visible at the head one cycle after it is accepted.
// Backpressure: none internally; the caller never reads when empty or writes when full.
module pq_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat,
    output logic [CNT_W-1:0] cnt
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    assign rd_dat = mem[rd_ptr];

    // Pointers wrap explicitly so non-power-of-two depths stay modulo DEPTH.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_vld) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_rdy) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({wr_vld, rd_rdy})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_vld) begin
            mem[wr_ptr] <= wr_dat;
        end
    end
endmodule

// Cell ID allocator in front of the priority queue.
// Latency: 1 cycle request-to-push; back-to-back requests give one push per cycle.
// Backpressure: req_ready_o drops while the free list is empty or a push is held by push_ready_i.
module pq_push_alloc #(
    parameter int QUEUE_DEPTH = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int CNT_WIDTH   = $clog2(QUEUE_DEPTH),
    parameter int ID_WIDTH    = CNT_WIDTH + 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [DATA_WIDTH-1:0]        req_data_i,
    output logic                         push_valid_o,
    input  logic                         push_ready_i,
    output logic [DATA_WIDTH+ID_WIDTH-1:0] push_cell_o,
    input  logic                         release_valid_i,
    input  logic [ID_WIDTH-1:0]          release_id_i,
    output logic [ID_WIDTH-1:0]          free_cnt_o,
    output logic                         init_done_o,
    output logic                         err_o
);
    localparam logic [ID_WIDTH-1:0] FULL_CNT = ID_WIDTH'(QUEUE_DEPTH);
    localparam logic [ID_WIDTH-1:0] LAST_ID  = ID_WIDTH'(QUEUE_DEPTH - 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t              state;
    logic [ID_WIDTH-1:0] init_id;
    logic [ID_WIDTH-1:0] head_id;
    logic [ID_WIDTH-1:0] fl_wr_dat;
    logic                fl_wr;
    logic                run;
    logic                alloc;
    logic                id_ok;
    logic                rel_ok;

    assign run         = (state == ST_RUN);
    assign req_ready_o = run && (free_cnt_o != '0) && (!push_valid_o || push_ready_i);
    assign alloc       = req_valid_i && req_ready_o;

`ifdef PQ_ALLOC_CHECK_EN
    logic [QUEUE_DEPTH-1:0] in_use;

    assign id_ok = (release_id_i < FULL_CNT) && in_use[release_id_i[CNT_WIDTH-1:0]];

    // Clear before set: an ID cannot be released and reallocated in the same cycle anyway.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            in_use <= '0;
        end else begin
            if (rel_ok) begin
                in_use[release_id_i[CNT_WIDTH-1:0]] <= 1'b0;
            end
            if (alloc) begin
                in_use[head_id[CNT_WIDTH-1:0]] <= 1'b1;
            end
        end
    end
`else
    assign id_ok = 1'b1;
`endif

    // A release that would overflow the list is dropped even if an allocate pops this cycle.
    assign rel_ok    = release_valid_i && run && (free_cnt_o != FULL_CNT) && id_ok;
    assign fl_wr     = run ? rel_ok : 1'b1;
    assign fl_wr_dat = run ? release_id_i : init_id;

    pq_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (ID_WIDTH),
        .CNT_W (ID_WIDTH)
    ) u_free_list (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .wr_vld (fl_wr),
        .wr_dat (fl_wr_dat),
        .rd_rdy (alloc),
        .rd_dat (head_id),
        .cnt    (free_cnt_o)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state        <= ST_INIT;
            init_id      <= '0;
            init_done_o  <= 1'b0;
            push_valid_o <= 1'b0;
            push_cell_o  <= '0;
            err_o        <= 1'b0;
        end else begin
            err_o <= release_valid_i && !rel_ok;

            if (state == ST_INIT) begin
                init_id <= init_id + 1'b1;
                if (init_id == LAST_ID) begin
                    state       <= ST_RUN;
                    init_done_o <= 1'b1;
                end
            end

            if (alloc) begin
                push_valid_o <= 1'b1;
                push_cell_o  <= {req_data_i, head_id};
            end else if (push_ready_i) begin
                push_valid_o <= 1'b0;
            end
        end
    end
endmodule
